alu181_slice_seq: RTL

//  Parametrised, multi-cycle successor to the team's combinational 74181-style ALU.

---
 rtl/alu181_slice_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu181_slice_seq.sv
// alu181_slice_seq
//   Multi-cycle 74181-style ALU. One SLICE-bit datapath is reused for
//   WIDTH/SLICE cycles. The carry is registered between slices, so the
//   block behaves like a time-multiplexed cascade of narrow ALUs.
//   There is a valid/ready handshake on the request side and on the result side.
//
// Ports
//   clk, rst_n        rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only while idle)
//   in_a, in_b        WIDTH-bit operands, sampled only at accept
//   select, mode      function select S3..S0; mode 1 = logic, 0 = arithmetic
//   carry_in          active-high carry into bit 0 (arithmetic only)
//   out_valid/out_ready result handshake
//   alu_out           WIDTH-bit result
//   carry_out         carry out of the top bit (0 in logic mode)
//   compare           captured A == captured B
//   zero              alu_out == 0
module alu181_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  input  logic             mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             compare,
  output logic             zero
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bitwise logic-mode function for one slice.
  function automatic logic [SLICE-1:0] logic_fn(input logic [3:0] s,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (s)
      4'h0: r = ~a;
      4'h1: r = ~(a | b);
      4'h2: r = ~a & b;
      4'h3: r = '0;
      4'h4: r = ~(a & b);
      4'h5: r = ~b;
      4'h6: r = a ^ b;
      4'h7: r = a & ~b;
      4'h8: r = ~a | b;
      4'h9: r = ~(a ^ b);
      4'hA: r = b;
      4'hB: r = a & b;
      4'hC: r = '1;
      4'hD: r = a | ~b;
      4'hE: r = a | b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Arithmetic-mode slice: X + Y + cin. The top bit of the result is the slice carry-out.
  function automatic logic [SLICE:0] arith_fn(input logic [3:0] s,
                                              input logic [SLICE-1:0] a,
                                              input logic [SLICE-1:0] b,
                                              input logic cin);
    logic [SLICE-1:0] x;
    logic [SLICE-1:0] y;
    case (s)
      4'h0: begin x = a;      y = '0;     end
      4'h1: begin x = a | b;  y = '0;     end
      4'h2: begin x = a | ~b; y = '0;     end
      4'h3: begin x = '0;     y = '1;     end
      4'h4: begin x = a;      y = a & ~b; end
      4'h5: begin x = a | b;  y = a & ~b; end
      4'h6: begin x = a;      y = ~b;     end
      4'h7: begin x = a & ~b; y = '1;     end
      4'h8: begin x = a;      y = a & b;  end
      4'h9: begin x = a;      y = b;      end
      4'hA: begin x = a | ~b; y = a & b;  end
      4'hB: begin x = a & b;  y = '1;     end
      4'hC: begin x = a;      y = a;      end
      4'hD: begin x = a | b;  y = a;      end
      4'hE: begin x = a | ~b; y = a;      end
      default: begin x = a;   y = '1;     end
    endcase
    return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_out_q, carry_out_d;
  logic             compare_q, compare_d;
  logic             zero_q, zero_d;

  // Slice datapath: the low SLICE bits of the shifting operand registers.
  logic [SLICE-1:0] sl_a, sl_b, sl_res;
  logic [SLICE:0]   sl_sum;
  logic             sl_cout;

  assign sl_a    = a_sh_q[SLICE-1:0];
  assign sl_b    = b_sh_q[SLICE-1:0];
  assign sl_sum  = arith_fn(sel_q, sl_a, sl_b, carry_q);
  assign sl_res  = mode_q ? logic_fn(sel_q, sl_a, sl_b) : sl_sum[SLICE-1:0];
  assign sl_cout = ~mode_q & sl_sum[SLICE];

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    eq_d        = eq_q;
    k_d         = k_q;
    alu_out_d   = alu_out_q;
    carry_out_d = carry_out_q;
    compare_d   = compare_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          sel_d   = select;
          mode_d  = mode;
          carry_d = carry_in & ~mode;
          eq_d    = (in_a == in_b);
          res_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands shift down one slice per cycle. The result fills in from the top,
        // so after NSL cycles slice 0 sits in the low bits.
        a_sh_d  = a_sh_q >> SLICE;
        b_sh_d  = b_sh_q >> SLICE;
        res_d   = (res_q >> SLICE) | (WIDTH'(sl_res) << (WIDTH - SLICE));
        carry_d = sl_cout;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d         = '0;
          state_d     = DONE;
          alu_out_d   = res_d;
          carry_out_d = sl_cout;
          compare_d   = eq_q;
          zero_d      = (res_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      sel_q       <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
      k_q         <= '0;
      alu_out_q   <= '0;
      carry_out_q <= 1'b0;
      compare_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      eq_q        <= eq_d;
      k_q         <= k_d;
      alu_out_q   <= alu_out_d;
      carry_out_q <= carry_out_d;
      compare_q   <= compare_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign alu_out   = alu_out_q;
  assign carry_out = carry_out_q;
  assign compare   = compare_q;
  assign zero      = zero_q;

endmodule
